fifo_drain: RTL and testbench



---
 rtl/fifo_drain_pkg.sv | 22 ++
 rtl/fifo_drain_skid.sv | 53 +++++
 rtl/fifo_drain.sv | 101 ++++++++++
 tb/tb_fifo_drain.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_e;

  localparam int DRAIN_SKID_DEPTH = 2;
  localparam int DRAIN_CNT_W      = 16;

  // A new read may issue only if the word it returns is guaranteed a skid slot.
  function automatic logic drain_credit_ok(input logic [1:0] occ,
                                           input logic       inflight,
                                           input logic       pop);
    logic [2:0] used;
    used = {1'b0, occ} + {2'b00, inflight};
    return used < (3'(DRAIN_SKID_DEPTH) + {2'b00, pop});
  endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry in-order skid buffer; the head entry register drives m_data directly.
module fifo_drain_skid #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data
);

  logic [FIFO_WIDTH-1:0] head_q;
  logic [FIFO_WIDTH-1:0] tail_q;
  logic [1:0]            occ_q;

  // Head only changes on push-into-empty or pop, so it holds while stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= din;
          else               tail_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_q <= tail_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ     = occ_q;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;

endmodule

// File: rtl/fifo_drain.sv
// FIFO read-side drain engine: issues reads, absorbs the 1-cycle read latency in a skid buffer.
// Optional beat counter enabled by defining FIFO_DRAIN_COUNT_EN.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic [FIFO_WIDTH-1:0]  fifo_data_out,
  input  logic                   fifo_underflow,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [FIFO_WIDTH-1:0]  m_data,
  output logic                   busy,
  output logic                   underflow_err
`ifdef FIFO_DRAIN_COUNT_EN
  ,
  output logic [DRAIN_CNT_W-1:0] beat_cnt
`endif
);

  if (SKID_DEPTH != DRAIN_SKID_DEPTH) begin : g_bad_skid_depth
    $error("fifo_drain: SKID_DEPTH must be 2");
  end

  drain_state_e state_q;
  drain_state_e state_d;
  logic         rd_vld_p1;
  logic         uf_err_q;
  logic [1:0]   occ;
  logic         pop;
  logic         push;

  assign pop        = m_valid & m_ready;
  assign fifo_rd_en = (state_q == RUN) & ~fifo_empty & drain_credit_ok(occ, rd_vld_p1, pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = STOP;
      STOP: begin
        if (en)              state_d = RUN;
        else if (!rd_vld_p1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- p0 -> p1: read request becomes a returning word one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld_p1 <= 1'b0;
    else        rd_vld_p1 <= fifo_rd_en;
  end

  // ---- p1 -> skid: accept the return unless the FIFO flagged underflow
  assign push = rd_vld_p1 & ~fifo_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           uf_err_q <= 1'b0;
    else if (rd_vld_p1 && fifo_underflow) uf_err_q <= 1'b1;
  end

  fifo_drain_skid #(
    .FIFO_WIDTH(FIFO_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .din    (fifo_data_out),
    .pop    (pop),
    .occ    (occ),
    .m_valid(m_valid),
    .m_data (m_data)
  );

  assign busy          = rd_vld_p1 | (occ != 2'd0);
  assign underflow_err = uf_err_q;

`ifdef FIFO_DRAIN_COUNT_EN
  logic [DRAIN_CNT_W-1:0] beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   beat_q <= '0;
    else if (pop) beat_q <= beat_q + DRAIN_CNT_W'(1);
  end

  assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a behavioural FIFO read port and a stream monitor.
module tb_fifo_drain;
  import fifo_drain_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         fifo_empty;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_underflow = 1'b0;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         busy;
  logic         underflow_err;
`ifdef FIFO_DRAIN_COUNT_EN
  logic [DRAIN_CNT_W-1:0] beat_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mem [0:255];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  int           uf_at = -1;
  logic         inf_src = 1'b0;

  logic [W-1:0] rx [0:255];
  int           rx_n = 0;
  int           viol = 0;
  int           stab_err = 0;
  int           occ_tb = 0;
  logic         inflight_tb = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  int           base;

  fifo_drain #(.FIFO_WIDTH(W), .SKID_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .busy          (busy),
    .underflow_err (underflow_err)
`ifdef FIFO_DRAIN_COUNT_EN
    ,
    .beat_cnt      (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO read port: data and underflow return one cycle after rd_en.
  assign fifo_empty = inf_src ? 1'b0 : (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out  <= mem[rd_ptr[7:0]];
      fifo_underflow <= (rd_ptr == uf_at);
      rd_ptr         <= rd_ptr + 1;
    end else begin
      fifo_underflow <= 1'b0;
    end
  end

  // Stream monitor: occupancy model, credit rule, hold-while-stalled, captured words.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_tb      <= 0;
      inflight_tb <= 1'b0;
      prev_stall  <= 1'b0;
    end else begin
      if (fifo_rd_en && (occ_tb + int'(inflight_tb) - int'(m_valid && m_ready) >= 2))
        viol <= viol + 1;
      if (m_valid !== (occ_tb != 0))
        viol <= viol + 1;
      if (prev_stall && (!m_valid || m_data !== prev_data))
        stab_err <= stab_err + 1;
      if (m_valid && m_ready) begin
        if (rx_n < 256) rx[rx_n] <= m_data;
        rx_n <= rx_n + 1;
      end
      prev_stall  <= m_valid && !m_ready;
      prev_data   <= m_data;
      occ_tb      <= occ_tb + int'(inflight_tb && !fifo_underflow) - int'(m_valid && m_ready);
      inflight_tb <= fifo_rd_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    tick(2);
    chk("rst_rd_en",  32'(fifo_rd_en), 0);
    chk("rst_valid",  32'(m_valid), 0);
    chk("rst_data",   32'(m_data), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_uferr",  32'(underflow_err), 0);
`ifdef FIFO_DRAIN_COUNT_EN
    chk("rst_beat",   32'(beat_cnt), 0);
`endif
    rst_n = 1'b1;
    tick(1);

    // Streaming at full rate: 5 words
    for (int i = 1; i <= 5; i++) load(W'(i));
    m_ready = 1'b1; en = 1'b1;
    base = rx_n;
    chk("t1_rd_en_idle", 32'(fifo_rd_en), 0);
    tick(1);
    chk("t1_rd_en_first", 32'(fifo_rd_en), 1);
    chk("t1_valid_n1", 32'(m_valid), 0);
    tick(1);
    chk("t1_valid_n1b", 32'(m_valid), 0);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk("t1_valid", 32'(m_valid), 1);
      chk("t1_data", 32'(m_data), k);
    end
    tick(1);
    chk("t1_valid_end", 32'(m_valid), 0);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_data_hold", 32'(m_data), 5);
    chk("t1_count", rx_n - base, 5);
    en = 1'b0;
    tick(3);

    // Backpressure: m_ready 1,0,0,1,...
    for (int i = 0; i < 8; i++) load(W'(16'h0020 + i));
    base = rx_n;
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick(1);
    end
    m_ready = 1'b1;
    tick(4);
    chk("t2_count", rx_n - base, 8);
    for (int i = 0; i < 8; i++) chk("t2_word", 32'(rx[base + i]), 32'h20 + i);
    chk("t2_credit", viol, 0);
    chk("t2_stable", stab_err, 0);
    chk("t2_busy", 32'(busy), 0);
    en = 1'b0;
    tick(3);

    // Drop en with a read in flight, then resume
    for (int i = 0; i < 6; i++) load(W'(16'h0030 + i));
    base = rx_n;
    en = 1'b1;
    tick(2);
    chk("t3_rd_en_last", 32'(fifo_rd_en), 1);
    en = 1'b0;
    tick(1);
    chk("t3_state_stop", 32'(dut.state_q), 32'(STOP));
    chk("t3_rd_en_off", 32'(fifo_rd_en), 0);
    chk("t3_data0", 32'(m_data), 32'h30);
    tick(1);
    chk("t3_state_stop2", 32'(dut.state_q), 32'(STOP));
    chk("t3_data1", 32'(m_data), 32'h31);
    tick(1);
    chk("t3_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t3_valid_off", 32'(m_valid), 0);
    tick(4);
    chk("t3_rd_en_quiet", 32'(fifo_rd_en), 0);
    chk("t3_count_stop", rx_n - base, 2);
    en = 1'b1;
    tick(12);
    chk("t3_count_all", rx_n - base, 6);
    for (int i = 0; i < 6; i++) chk("t3_word", 32'(rx[base + i]), 32'h30 + i);
    en = 1'b0;
    tick(3);

    // Underflow on the second return
    chk("t4_uferr_pre", 32'(underflow_err), 0);
    uf_at = wr_ptr + 1;
    for (int i = 1; i <= 4; i++) load(W'(16'h0040 + i));
    base = rx_n;
    en = 1'b1;
    tick(12);
    chk("t4_count", rx_n - base, 3);
    chk("t4_w0", 32'(rx[base]),     32'h41);
    chk("t4_w1", 32'(rx[base + 1]), 32'h43);
    chk("t4_w2", 32'(rx[base + 2]), 32'h44);
    chk("t4_uferr", 32'(underflow_err), 1);
    en = 1'b0;
    tick(5);
    chk("t4_uferr_sticky", 32'(underflow_err), 1);
    chk("t4_busy", 32'(busy), 0);

    // Reset with a word held and one in flight
    for (int i = 1; i <= 5; i++) load(W'(16'h0050 + i));
    m_ready = 1'b0;
    en = 1'b1;
    tick(3);
    chk("t5_pre_valid", 32'(m_valid), 1);
    chk("t5_pre_data", 32'(m_data), 32'h51);
    chk("t5_pre_busy", 32'(busy), 1);
    #1 rst_n = 1'b0; en = 1'b0;
    #1;
    chk("t5_rd_en", 32'(fifo_rd_en), 0);
    chk("t5_valid", 32'(m_valid), 0);
    chk("t5_data", 32'(m_data), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_uferr", 32'(underflow_err), 0);
`ifdef FIFO_DRAIN_COUNT_EN
    chk("t5_beat", 32'(beat_cnt), 0);
`endif
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    base = rx_n;
    tick(5);
    chk("t5_no_ghost", rx_n - base, 0);
    chk("t5_valid_after", 32'(m_valid), 0);
    chk("t5_busy_after", 32'(busy), 0);
    chk("final_credit", viol, 0);
    chk("final_stable", stab_err, 0);

`ifdef FIFO_DRAIN_COUNT_EN
    // Counter wrap: 0x10000 + 3 accepted beats
    inf_src = 1'b1;
    base = rx_n;
    en = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      tick(1);
      if (rx_n - base >= 65539) break;
    end
    m_ready = 1'b0;
    chk("t6_beats", rx_n - base, 65539);
    chk("t6_beat_cnt", 32'(beat_cnt), 3);
    en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
